// File: rtl/decode_pkg.sv
// Shared types, opcode map and decode helpers for the decode/issue stage.
//
// Instruction word layout (32 bits):
//   [31:25] opcode   [24:20] rd / OFFSET_HI   [19:15] ra / OFFSET_M
//   [14:10] rb       [9:0]   OFFSET_LO
// Opcodes 0x00..0x07 form the R-type space; NOP lives inside that space.
package decode_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_W       = 32;
    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int OPCODE_W   = 7;

    // R-type space
    localparam logic [OPCODE_W-1:0] OPC_ADD  = 7'h00;
    localparam logic [OPCODE_W-1:0] OPC_SUB  = 7'h01;
    localparam logic [OPCODE_W-1:0] OPC_MUL  = 7'h02;
    localparam logic [OPCODE_W-1:0] OPC_AND  = 7'h03;
    localparam logic [OPCODE_W-1:0] OPC_OR   = 7'h04;
    localparam logic [OPCODE_W-1:0] OPC_NOP  = 7'h07;
    // Immediate, memory and control-flow
    localparam logic [OPCODE_W-1:0] OPC_ADDI = 7'h08;
    localparam logic [OPCODE_W-1:0] OPC_LDB  = 7'h10;
    localparam logic [OPCODE_W-1:0] OPC_LDW  = 7'h11;
    localparam logic [OPCODE_W-1:0] OPC_STB  = 7'h12;
    localparam logic [OPCODE_W-1:0] OPC_STW  = 7'h13;
    localparam logic [OPCODE_W-1:0] OPC_BEQ  = 7'h30;
    localparam logic [OPCODE_W-1:0] OPC_JUMP = 7'h31;

    typedef struct packed {
        logic xcpt_itlb_miss;
        logic xcpt_bus_error;
    } fetch_xcpt_t;

    typedef struct packed {
        logic            xcpt_illegal_instr;
        logic [PC_W-1:0] xcpt_pc;
    } decode_xcpt_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [REG_ADDR_W-1:0] ra_addr;
        logic [REG_ADDR_W-1:0] rb_addr;
        logic [REG_DATA_W-1:0] ra_data;
        logic [REG_DATA_W-1:0] rb_data;
        logic [REG_DATA_W-1:0] offset;
        logic                  is_load;
        logic                  is_store;
    } alu_request_t;

    function automatic logic is_r_type_instr(input logic [OPCODE_W-1:0] op);
        return op[OPCODE_W-1:3] == 4'b0000;
    endfunction

    function automatic logic is_alu_supported(input logic [OPCODE_W-1:0] op);
        return (op == OPC_ADD) || (op == OPC_SUB) || (op == OPC_MUL) ||
               (op == OPC_AND) || (op == OPC_OR);
    endfunction

    function automatic logic is_load_instr(input logic [OPCODE_W-1:0] op);
        return (op == OPC_LDB) || (op == OPC_LDW);
    endfunction

    function automatic logic is_store_instr(input logic [OPCODE_W-1:0] op);
        return (op == OPC_STB) || (op == OPC_STW);
    endfunction

    // Unsupported R-type opcodes still read ra/rb so they flow like any ALU op.
    function automatic logic uses_src1(input logic [OPCODE_W-1:0] op);
        return (is_r_type_instr(op) && (op != OPC_NOP)) || (op == OPC_ADDI) ||
               is_load_instr(op) || is_store_instr(op) || (op == OPC_BEQ);
    endfunction

    function automatic logic uses_src2(input logic [OPCODE_W-1:0] op);
        return (is_r_type_instr(op) && (op != OPC_NOP)) ||
               is_store_instr(op) || (op == OPC_BEQ);
    endfunction

    // Zero-extended immediate; BEQ and JUMP reuse register fields as offset bits.
    function automatic logic [REG_DATA_W-1:0] decode_offset(input logic [INSTR_W-1:0] instr);
        logic [REG_DATA_W-1:0] off;
        off = {17'd0, instr[14:0]};
        if (instr[31:25] == OPC_BEQ) begin
            off = {17'd0, instr[24:20], instr[9:0]};
        end else if (instr[31:25] == OPC_JUMP) begin
            off = {12'd0, instr[24:20], instr[19:15], instr[9:0]};
        end
        return off;
    endfunction

endpackage

// File: rtl/decode_bypass_mux.sv
// Priority operand select for one source: the lowest-index valid bypass
// channel that targets the source wins, otherwise register-file data.
// r0 always reads as zero and never reports a bypass hit.
module decode_bypass_mux #(
    parameter int NUM_BYP = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic [ADDR_W-1:0]         src_addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [NUM_BYP*ADDR_W-1:0] byp_addr,
    input  logic [NUM_BYP*DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0]         operand,
    output logic                      hit
);

    // Scan from the oldest channel down so channel 0 (youngest) overrides last.
    always_comb begin
        operand = rf_data;
        hit     = 1'b0;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (byp_valid[i] && (byp_addr[i*ADDR_W +: ADDR_W] == src_addr)) begin
                operand = byp_data[i*DATA_W +: DATA_W];
                hit     = 1'b1;
            end
        end
        if (src_addr == '0) begin
            operand = '0;
            hit     = 1'b0;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage between fetch and the ALU: decodes the fetched word,
// reads the register file, applies prioritised bypasses, tracks in-flight
// loads in a scoreboard and issues through a single registered output slot.
// DATA_W must match REG_DATA_W because alu_request_t has fixed field widths.
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int NUM_BYP  = 2,
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      fetch_valid,
    output logic                      fetch_ready,
    input  logic [INSTR_W-1:0]        fetch_instr,
    input  logic [PC_W-1:0]           fetch_pc,
    input  fetch_xcpt_t               fetch_xcpt_in,
    output logic [ADDR_W-1:0]         rf_src1_addr,
    output logic [ADDR_W-1:0]         rf_src2_addr,
    input  logic [DATA_W-1:0]         rf_src1_data,
    input  logic [DATA_W-1:0]         rf_src2_data,
    input  logic [NUM_BYP-1:0]        byp_valid,
    input  logic [NUM_BYP*ADDR_W-1:0] byp_addr,
    input  logic [NUM_BYP*DATA_W-1:0] byp_data,
    input  logic                      ld_done_valid,
    input  logic [ADDR_W-1:0]         ld_done_addr,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output alu_request_t              alu_info,
    output logic [PC_W-1:0]           alu_pc,
    output fetch_xcpt_t               alu_fetch_xcpt,
    output decode_xcpt_t              decode_xcpt
);

    logic [OPCODE_W-1:0] opcode_p0;
    logic [ADDR_W-1:0]   rd_p0;
    logic [ADDR_W-1:0]   ra_p0;
    logic [ADDR_W-1:0]   rb_p0;
    logic [ADDR_W-1:0]   src2_p0;
    logic                use1_p0;
    logic                use2_p0;
    logic                load_p0;
    logic                store_p0;
    logic                illegal_p0;
    logic [DATA_W-1:0]   ra_data_p0;
    logic [DATA_W-1:0]   rb_data_p0;
    logic                ra_hit_p0;
    logic                rb_hit_p0;
    logic                hazard_p0;
    logic                accept_p0;
    alu_request_t        req_p0;
    decode_xcpt_t        dxcpt_p0;

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    logic                vld_p1;
    logic                slot_free_p1;
    alu_request_t        info_p1;
    logic [PC_W-1:0]     pc_p1;
    fetch_xcpt_t         fxcpt_p1;
    decode_xcpt_t        dxcpt_p1;

    // ---- p0: field extraction and register-file addressing
    assign opcode_p0  = fetch_instr[31:25];
    assign rd_p0      = fetch_instr[24:20];
    assign ra_p0      = fetch_instr[19:15];
    assign rb_p0      = fetch_instr[14:10];
    assign use1_p0    = uses_src1(opcode_p0);
    assign use2_p0    = uses_src2(opcode_p0);
    assign load_p0    = is_load_instr(opcode_p0);
    assign store_p0   = is_store_instr(opcode_p0);
    assign illegal_p0 = is_r_type_instr(opcode_p0) && (opcode_p0 != OPC_NOP) &&
                        !is_alu_supported(opcode_p0);

    // Stores read their data register through port B.
    assign src2_p0      = store_p0 ? rd_p0 : rb_p0;
    assign rf_src1_addr = ra_p0;
    assign rf_src2_addr = src2_p0;

    decode_bypass_mux #(
        .NUM_BYP (NUM_BYP),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_byp_src1 (
        .src_addr  (ra_p0),
        .rf_data   (rf_src1_data),
        .byp_valid (byp_valid),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .operand   (ra_data_p0),
        .hit       (ra_hit_p0)
    );

    decode_bypass_mux #(
        .NUM_BYP (NUM_BYP),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_byp_src2 (
        .src_addr  (src2_p0),
        .rf_data   (rf_src2_data),
        .byp_valid (byp_valid),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .operand   (rb_data_p0),
        .hit       (rb_hit_p0)
    );

    // ---- p0: hazard detection and handshake
    // A pending load blocks only when no bypass delivers its result this cycle.
    assign hazard_p0 = (use1_p0 && (ra_p0 != '0) && sb_q[ra_p0] && !ra_hit_p0) ||
                       (use2_p0 && (src2_p0 != '0) && sb_q[src2_p0] && !rb_hit_p0);

    assign slot_free_p1 = !vld_p1 || alu_ready;
    assign fetch_ready  = slot_free_p1 && !hazard_p0 && !flush;
    assign accept_p0    = fetch_valid && fetch_ready;

    // Assemble the request and decode exception for the slot.
    always_comb begin
        req_p0          = '0;
        req_p0.opcode   = opcode_p0;
        req_p0.rd_addr  = rd_p0;
        req_p0.ra_addr  = ra_p0;
        req_p0.rb_addr  = src2_p0;
        req_p0.ra_data  = ra_data_p0;
        req_p0.rb_data  = rb_data_p0;
        req_p0.offset   = decode_offset(fetch_instr);
        req_p0.is_load  = load_p0;
        req_p0.is_store = store_p0;

        dxcpt_p0 = '0;
        if (illegal_p0) begin
            dxcpt_p0.xcpt_illegal_instr = 1'b1;
            dxcpt_p0.xcpt_pc            = fetch_pc;
        end
    end

    // Scoreboard next state: the completing load clears, a new load sets.
    // The set is applied last so a younger load to the same rd keeps the bit.
    always_comb begin
        sb_d = sb_q;
        if (ld_done_valid) begin
            sb_d[ld_done_addr] = 1'b0;
        end
        if (accept_p0 && load_p0 && (rd_p0 != '0)) begin
            sb_d[rd_p0] = 1'b1;
        end
    end

    // Scoreboard register; reset and flush discard every in-flight load.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // ---- p1: output slot, loaded on accept and held under back-pressure
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            info_p1  <= '0;
            pc_p1    <= '0;
            fxcpt_p1 <= '0;
            dxcpt_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            info_p1  <= req_p0;
            pc_p1    <= fetch_pc;
            fxcpt_p1 <= fetch_xcpt_in;
            dxcpt_p1 <= dxcpt_p0;
        end else if (slot_free_p1) begin
            vld_p1 <= 1'b0;
        end
    end

    assign alu_valid      = vld_p1;
    assign alu_info       = info_p1;
    assign alu_pc         = pc_p1;
    assign alu_fetch_xcpt = fxcpt_p1;
    assign decode_xcpt    = dxcpt_p1;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a table of single-issue vectors
// followed by hand-written multi-cycle sequences (load-use, back-pressure,
// flush, scoreboard set/clear, r0 loads, mid-run reset).
module tb_decode_issue_stage;
    import decode_pkg::*;

    logic         clock;
    logic         reset;
    logic         flush;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [31:0]  fetch_instr;
    logic [31:0]  fetch_pc;
    fetch_xcpt_t  fetch_xcpt_in;
    logic [4:0]   rf_src1_addr;
    logic [4:0]   rf_src2_addr;
    logic [31:0]  rf_src1_data;
    logic [31:0]  rf_src2_data;
    logic [1:0]   byp_valid;
    logic [9:0]   byp_addr;
    logic [63:0]  byp_data;
    logic         ld_done_valid;
    logic [4:0]   ld_done_addr;
    logic         alu_valid;
    logic         alu_ready;
    alu_request_t alu_info;
    logic [31:0]  alu_pc;
    fetch_xcpt_t  alu_fetch_xcpt;
    decode_xcpt_t decode_xcpt;

    int n_cmp = 0;
    int n_err = 0;

    decode_issue_stage #(
        .NUM_BYP  (2),
        .NUM_REGS (32),
        .DATA_W   (32),
        .ADDR_W   (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_xcpt_in  (fetch_xcpt_in),
        .rf_src1_addr   (rf_src1_addr),
        .rf_src2_addr   (rf_src2_addr),
        .rf_src1_data   (rf_src1_data),
        .rf_src2_data   (rf_src2_data),
        .byp_valid      (byp_valid),
        .byp_addr       (byp_addr),
        .byp_data       (byp_data),
        .ld_done_valid  (ld_done_valid),
        .ld_done_addr   (ld_done_addr),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_info       (alu_info),
        .alu_pc         (alu_pc),
        .alu_fetch_xcpt (alu_fetch_xcpt),
        .decode_xcpt    (decode_xcpt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file stand-in: register n reads as 0xA000_0000 | n.
    always_comb rf_src1_data = 32'hA000_0000 | {27'd0, rf_src1_addr};
    always_comb rf_src2_data = 32'hA000_0000 | {27'd0, rf_src2_addr};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fx;
        logic [1:0]  bv;
        logic [4:0]  ba0;
        logic [31:0] bd0;
        logic [4:0]  ba1;
        logic [31:0] bd1;
        logic [4:0]  e_src1;
        logic [4:0]  e_src2;
        logic        chk_data;
        logic [31:0] e_ra;
        logic [31:0] e_rb;
        logic [31:0] e_off;
        logic        e_ill;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [9:0] lo);
        return {op, rd, ra, rb, lo};
    endfunction

    function automatic vec_t mkv(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                 input logic [4:0] rb, input logic [9:0] lo, input logic [31:0] pc,
                                 input logic [1:0] fx, input logic [1:0] bv,
                                 input logic [4:0] ba0, input logic [31:0] bd0,
                                 input logic [4:0] ba1, input logic [31:0] bd1,
                                 input logic [4:0] e_src2, input logic chk_data,
                                 input logic [31:0] e_ra, input logic [31:0] e_rb,
                                 input logic [31:0] e_off, input logic e_ill);
        vec_t v;
        v.instr = enc(op, rd, ra, rb, lo);
        v.pc = pc; v.fx = fx; v.bv = bv;
        v.ba0 = ba0; v.bd0 = bd0; v.ba1 = ba1; v.bd1 = bd1;
        v.e_src1 = ra; v.e_src2 = e_src2; v.chk_data = chk_data;
        v.e_ra = e_ra; v.e_rb = e_rb; v.e_off = e_off; v.e_ill = e_ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drv(input logic [31:0] instr, input logic [31:0] pc);
        fetch_valid   = 1'b1;
        fetch_instr   = instr;
        fetch_pc      = pc;
        fetch_xcpt_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Vector table: {instr fields, pc, fetch xcpt, bypass}, {expected}
        vecs[0]  = mkv(OPC_ADD,  5'd4,  5'd3, 5'd2, 10'h000, 32'h100, 2'b00, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,
                       5'd2,  1'b1, 32'hA000_0003, 32'hA000_0002, 32'h0000_0800, 1'b0);
        vecs[1]  = mkv(OPC_ADD,  5'd4,  5'd3, 5'd2, 10'h000, 32'h104, 2'b00, 2'b11, 5'd3, 32'hAAAA, 5'd3, 32'h5555,
                       5'd2,  1'b1, 32'h0000_AAAA, 32'hA000_0002, 32'h0000_0800, 1'b0);
        vecs[2]  = mkv(OPC_ADD,  5'd4,  5'd3, 5'd2, 10'h000, 32'h108, 2'b00, 2'b10, 5'd3, 32'hAAAA, 5'd3, 32'h5555,
                       5'd2,  1'b1, 32'h0000_5555, 32'hA000_0002, 32'h0000_0800, 1'b0);
        vecs[3]  = mkv(OPC_ADD,  5'd5,  5'd0, 5'd3, 10'h000, 32'h10C, 2'b00, 2'b01, 5'd0, 32'h1111, 5'd0, 32'h0,
                       5'd3,  1'b1, 32'h0000_0000, 32'hA000_0003, 32'h0000_0C00, 1'b0);
        vecs[4]  = mkv(OPC_ADD,  5'd1,  5'd3, 5'd2, 10'h000, 32'h110, 2'b00, 2'b11, 5'd3, 32'hCCCC, 5'd2, 32'hBBBB,
                       5'd2,  1'b1, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_0800, 1'b0);
        vecs[5]  = mkv(OPC_ADDI, 5'd6,  5'd1, 5'h1F, 10'h3FF, 32'h114, 2'b00, 2'b00, 5'd0, 32'h0,   5'd0, 32'h0,
                       5'h1F, 1'b1, 32'hA000_0001, 32'hA000_001F, 32'h0000_7FFF, 1'b0);
        vecs[6]  = mkv(OPC_STW,  5'd7,  5'd2, 5'd0, 10'h010, 32'h118, 2'b00, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,
                       5'd7,  1'b1, 32'hA000_0002, 32'hA000_0007, 32'h0000_0010, 1'b0);
        vecs[7]  = mkv(OPC_BEQ,  5'h15, 5'd1, 5'd2, 10'h2AA, 32'h11C, 2'b00, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,
                       5'd2,  1'b1, 32'hA000_0001, 32'hA000_0002, 32'h0000_56AA, 1'b0);
        vecs[8]  = mkv(OPC_JUMP, 5'h1F, 5'd1, 5'd0, 10'h001, 32'h120, 2'b00, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,
                       5'd0,  1'b0, 32'h0,         32'h0,         32'h000F_8401, 1'b0);
        vecs[9]  = mkv(7'h05,    5'd1,  5'd2, 5'd3, 10'h000, 32'h02C, 2'b00, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,
                       5'd3,  1'b1, 32'hA000_0002, 32'hA000_0003, 32'h0000_0C00, 1'b1);
        vecs[10] = mkv(OPC_NOP,  5'd0,  5'd0, 5'd0, 10'h000, 32'h030, 2'b00, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,
                       5'd0,  1'b0, 32'h0,         32'h0,         32'h0000_0000, 1'b0);
        vecs[11] = mkv(OPC_ADD,  5'd2,  5'd1, 5'd1, 10'h000, 32'h034, 2'b10, 2'b00, 5'd0, 32'h0,    5'd0, 32'h0,
                       5'd1,  1'b1, 32'hA000_0001, 32'hA000_0001, 32'h0000_0400, 1'b0);
        vecs[12] = mkv(OPC_ADD,  5'd3,  5'd4, 5'd5, 10'h000, 32'h038, 2'b00, 2'b00, 5'd4, 32'hDEAD, 5'd0, 32'h0,
                       5'd5,  1'b1, 32'hA000_0004, 32'hA000_0005, 32'h0000_1400, 1'b0);

        reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
        fetch_xcpt_in = '0; byp_valid = '0; byp_addr = '0; byp_data = '0;
        ld_done_valid = 1'b0; ld_done_addr = '0; alu_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_alu_valid",   64'(alu_valid), 64'd0);
        chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        chk("rst_alu_pc",      64'(alu_pc), 64'd0);
        chk("rst_alu_info",    64'(|alu_info), 64'd0);
        chk("rst_xcpts",       64'(|decode_xcpt | |alu_fetch_xcpt), 64'd0);
        @(negedge clock);

        // Back-to-back single-issue vectors with alu_ready held high.
        for (int i = 0; i < 13; i++) begin
            fetch_valid   = 1'b1;
            fetch_instr   = vecs[i].instr;
            fetch_pc      = vecs[i].pc;
            fetch_xcpt_in = vecs[i].fx;
            byp_valid     = vecs[i].bv;
            byp_addr      = {vecs[i].ba1, vecs[i].ba0};
            byp_data      = {vecs[i].bd1, vecs[i].bd0};
            #1;
            chk($sformatf("v%0d_fetch_ready", i), 64'(fetch_ready), 64'd1);
            chk($sformatf("v%0d_src1_addr", i), 64'(rf_src1_addr), 64'(vecs[i].e_src1));
            chk($sformatf("v%0d_src2_addr", i), 64'(rf_src2_addr), 64'(vecs[i].e_src2));
            step();
            chk($sformatf("v%0d_alu_valid", i), 64'(alu_valid), 64'd1);
            chk($sformatf("v%0d_alu_pc", i), 64'(alu_pc), 64'(vecs[i].pc));
            chk($sformatf("v%0d_opcode", i), 64'(alu_info.opcode), 64'(vecs[i].instr[31:25]));
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_ra_data", i), 64'(alu_info.ra_data), 64'(vecs[i].e_ra));
                chk($sformatf("v%0d_rb_data", i), 64'(alu_info.rb_data), 64'(vecs[i].e_rb));
            end
            chk($sformatf("v%0d_offset", i), 64'(alu_info.offset), 64'(vecs[i].e_off));
            chk($sformatf("v%0d_illegal", i), 64'(decode_xcpt.xcpt_illegal_instr), 64'(vecs[i].e_ill));
            if (vecs[i].e_ill) begin
                chk($sformatf("v%0d_xcpt_pc", i), 64'(decode_xcpt.xcpt_pc), 64'(vecs[i].pc));
            end
            chk($sformatf("v%0d_fetch_xcpt", i), 64'(alu_fetch_xcpt), 64'(vecs[i].fx));
        end
        byp_valid = '0;

        // Load-use: LDW r5 then ADD r6,r5,r1, released by bypass, then by ld_done.
        drv(enc(OPC_LDW, 5'd5, 5'd1, 5'd0, 10'h004), 32'h400);
        #1 chk("lu_ldw_ready", 64'(fetch_ready), 64'd1);
        step();
        chk("lu_ldw_issued", 64'(alu_info.is_load), 64'd1);
        drv(enc(OPC_ADD, 5'd6, 5'd5, 5'd1, 10'h000), 32'h404);
        #1 chk("lu_stall0", 64'(fetch_ready), 64'd0);
        step();
        chk("lu_slot_drained", 64'(alu_valid), 64'd0);
        chk("lu_stall1", 64'(fetch_ready), 64'd0);
        byp_valid = 2'b01; byp_addr = {5'd0, 5'd5}; byp_data = {32'h0, 32'h1234};
        #1 chk("lu_byp_ready", 64'(fetch_ready), 64'd1);
        step();
        byp_valid = '0;
        chk("lu_byp_pc", 64'(alu_pc), 64'h404);
        chk("lu_byp_ra", 64'(alu_info.ra_data), 64'h1234);
        chk("lu_byp_rb", 64'(alu_info.rb_data), 64'hA000_0001);
        drv(enc(OPC_ADD, 5'd6, 5'd5, 5'd1, 10'h000), 32'h408);
        ld_done_valid = 1'b1; ld_done_addr = 5'd5;
        #1 chk("lu_done_same_cycle", 64'(fetch_ready), 64'd0);
        step();
        ld_done_valid = 1'b0;
        #1 chk("lu_done_ready", 64'(fetch_ready), 64'd1);
        step();
        chk("lu_done_pc", 64'(alu_pc), 64'h408);
        chk("lu_done_ra", 64'(alu_info.ra_data), 64'hA000_0005);

        // Back-pressure: slot held for three cycles, then the next one issues once.
        drv(enc(OPC_ADD, 5'd1, 5'd2, 5'd3, 10'h000), 32'h500);
        step();
        chk("bp_first_pc", 64'(alu_pc), 64'h500);
        drv(enc(OPC_SUB, 5'd4, 5'd5, 5'd6, 10'h000), 32'h504);
        alu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp_ready_%0d", k), 64'(fetch_ready), 64'd0);
            step();
            chk($sformatf("bp_valid_%0d", k), 64'(alu_valid), 64'd1);
            chk($sformatf("bp_pc_%0d", k), 64'(alu_pc), 64'h500);
            chk($sformatf("bp_ra_%0d", k), 64'(alu_info.ra_data), 64'hA000_0002);
        end
        alu_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(fetch_ready), 64'd1);
        step();
        chk("bp_second_pc", 64'(alu_pc), 64'h504);
        chk("bp_second_op", 64'(alu_info.opcode), 64'(OPC_SUB));
        fetch_valid = 1'b0;
        step();
        chk("bp_drained", 64'(alu_valid), 64'd0);

        // Flush with r7 scoreboarded and the slot full.
        drv(enc(OPC_LDW, 5'd7, 5'd1, 5'd0, 10'h000), 32'h600);
        step();
        chk("fl_ldw_valid", 64'(alu_valid), 64'd1);
        alu_ready = 1'b0;
        flush = 1'b1;
        drv(enc(OPC_ADD, 5'd1, 5'd7, 5'd7, 10'h000), 32'h604);
        #1 chk("fl_no_accept", 64'(fetch_ready), 64'd0);
        step();
        flush = 1'b0;
        chk("fl_valid_cleared", 64'(alu_valid), 64'd0);
        #1 chk("fl_r7_cleared", 64'(fetch_ready), 64'd1);
        alu_ready = 1'b1;
        step();
        chk("fl_add_pc", 64'(alu_pc), 64'h604);
        chk("fl_add_ra", 64'(alu_info.ra_data), 64'hA000_0007);

        // Same-cycle clear of r9 and set by a younger LDW r9: the bit survives.
        drv(enc(OPC_LDW, 5'd9, 5'd1, 5'd0, 10'h000), 32'h700);
        step();
        drv(enc(OPC_LDW, 5'd9, 5'd2, 5'd0, 10'h000), 32'h704);
        ld_done_valid = 1'b1; ld_done_addr = 5'd9;
        #1 chk("sc_second_ldw_ready", 64'(fetch_ready), 64'd1);
        step();
        ld_done_valid = 1'b0;
        drv(enc(OPC_ADD, 5'd2, 5'd9, 5'd0, 10'h000), 32'h708);
        #1 chk("sc_r9_still_set", 64'(fetch_ready), 64'd0);
        ld_done_valid = 1'b1; ld_done_addr = 5'd9;
        step();
        ld_done_valid = 1'b0;
        #1 chk("sc_r9_released", 64'(fetch_ready), 64'd1);
        step();
        chk("sc_add_pc", 64'(alu_pc), 64'h708);

        // A load to r0 never blocks a reader of r0.
        drv(enc(OPC_LDW, 5'd0, 5'd1, 5'd0, 10'h000), 32'h800);
        step();
        drv(enc(OPC_ADD, 5'd1, 5'd0, 5'd0, 10'h000), 32'h804);
        #1 chk("r0_no_hazard", 64'(fetch_ready), 64'd1);
        step();
        chk("r0_ra_zero", 64'(alu_info.ra_data), 64'd0);

        // Reset mid-run with r8 scoreboarded and the slot full.
        drv(enc(OPC_LDW, 5'd8, 5'd1, 5'd0, 10'h000), 32'h900);
        step();
        fetch_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_valid", 64'(alu_valid), 64'd0);
        chk("mr_pc", 64'(alu_pc), 64'd0);
        chk("mr_info", 64'(|alu_info), 64'd0);
        drv(enc(OPC_ADD, 5'd1, 5'd8, 5'd8, 10'h000), 32'h904);
        #1 chk("mr_r8_cleared", 64'(fetch_ready), 64'd1);
        step();
        chk("mr_add_pc", 64'(alu_pc), 64'h904);
        fetch_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
